// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave). It allows one outstanding request at a time.
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_rvalid, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// PC/fetch stage in front of IF/ID. It keeps one outstanding imem request and a
// one-entry output slot, handles execute redirects, and drives NOP bubbles when the slot is empty.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  fetch_stage_if.master         imem,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PC_PlusF,
  output logic                  fetch_valid
);

  localparam logic [DATA_WIDTH-1:0] PC_INC = DATA_WIDTH'(4);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  slot_valid_q, slot_valid_d;
  logic [DATA_WIDTH-1:0] slot_instr_q, slot_instr_d;
  logic [DATA_WIDTH-1:0] slot_pc_q, slot_pc_d;
  logic                  req_ok;

  // A request issues only when the slot is empty or is being consumed this edge.
  // This guarantees the slot is free when the response arrives.
  assign req_ok = (state_q == IDLE) && !PCSrcE && (!slot_valid_q || !stall);

  assign imem.imem_req  = req_ok && !rst;
  assign imem.imem_addr = fetch_pc_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    slot_valid_d = slot_valid_q;
    slot_instr_d = slot_instr_q;
    slot_pc_d    = slot_pc_q;

    if (!stall && slot_valid_q) slot_valid_d = 1'b0;

    if (PCSrcE) begin
      // A redirect takes priority over everything. A response that lands now, or
      // that is still in flight, belongs to the wrong path.
      fetch_pc_d   = {PCTargetE[DATA_WIDTH-1:2], 2'b00};
      slot_valid_d = 1'b0;
      if (state_q == WAIT) state_d = imem.imem_rvalid ? IDLE : DISCARD;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_ok) begin
            state_d    = WAIT;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_INC;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            state_d      = IDLE;
            slot_valid_d = 1'b1;
            slot_instr_d = imem.imem_rdata;
            slot_pc_d    = req_pc_q;
          end
        end
        DISCARD: begin
          if (imem.imem_rvalid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= '0;
      slot_valid_q <= 1'b0;
      slot_instr_q <= NOP_INSTR;
      slot_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      slot_valid_q <= slot_valid_d;
      slot_instr_q <= slot_instr_d;
      slot_pc_q    <= slot_pc_d;
    end
  end

  always_comb begin
    if (slot_valid_q) begin
      InstrF      = slot_instr_q;
      PCF         = slot_pc_q;
      PC_PlusF    = slot_pc_q + PC_INC;
      fetch_valid = 1'b1;
    end else begin
      InstrF      = NOP_INSTR;
      PCF         = '0;
      PC_PlusF    = '0;
      fetch_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A behavioural imem with programmable latency drives the bus.
// Every check compares DUT outputs against hand-computed values at the negedge.
module tb_fetch_stage;
  localparam int DW = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          PCSrcE;
  logic [DW-1:0] PCTargetE;
  logic [DW-1:0] InstrF, PCF, PC_PlusF;
  logic          fetch_valid;

  int errors = 0;
  int checks = 0;
  int lat = 1;

  fetch_stage_if #(.DATA_WIDTH(DW)) ifc ();

  fetch_stage #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem(ifc.master), .InstrF(InstrF), .PCF(PCF), .PC_PlusF(PC_PlusF),
    .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return 32'hA000_0000 | a;
  endfunction

  // Memory model: a request at edge N is sampled with rvalid at edge N+lat
  logic        pend;
  int          cnt;
  logic [31:0] paddr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend            <= 1'b0;
      cnt             <= 0;
      paddr           <= '0;
      ifc.imem_rvalid <= 1'b0;
      ifc.imem_rdata  <= '0;
    end else begin
      ifc.imem_rvalid <= 1'b0;
      if (pend) begin
        if (cnt == 1) begin
          ifc.imem_rvalid <= 1'b1;
          ifc.imem_rdata  <= memf(paddr);
          pend            <= 1'b0;
        end else cnt <= cnt - 1;
      end
      if (ifc.imem_req) begin
        if (lat == 1) begin
          ifc.imem_rvalid <= 1'b1;
          ifc.imem_rdata  <= memf(ifc.imem_addr);
        end else begin
          pend  <= 1'b1;
          paddr <= ifc.imem_addr;
          cnt   <= lat - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] i,
                         input logic [31:0] p, input logic [31:0] pp);
    chk({tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, v});
    chk({tag, ".instr"}, InstrF, i);
    chk({tag, ".pc"}, PCF, p);
    chk({tag, ".pcplus"}, PC_PlusF, pp);
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
    chk({tag, ".req"}, {31'd0, ifc.imem_req}, {31'd0, r});
    if (r) chk({tag, ".addr"}, ifc.imem_addr, a);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    #1;
    chk_req("rst_hold", 1'b0, 32'h0);
    tick; tick;
    rst = 1'b0; #1;
    // Reset state
    chk_out("reset", 1'b0, NOP, 32'h0, 32'h0);
    chk_req("req0", 1'b1, 32'h0);
    tick;                                           // request 0
    chk_req("wait0", 1'b0, 32'h0);
    chk_out("wait0", 1'b0, NOP, 32'h0, 32'h0);
    tick;                                           // slot <= instr@0
    chk_out("i0", 1'b1, 32'h00A0_0093, 32'h0, 32'h4);
    chk_req("req4", 1'b1, 32'h4);
    tick;                                           // consume, request 4
    chk_out("bubble", 1'b0, NOP, 32'h0, 32'h0);
    chk_req("wait4", 1'b0, 32'h0);
    tick;
    chk_out("i4", 1'b1, 32'h0010_0113, 32'h4, 32'h8);
    chk_req("req8", 1'b1, 32'h8);
    tick; tick;                                     // slot <= instr@8

    // Stall with a full slot
    chk_out("i8", 1'b1, 32'hA000_0008, 32'h8, 32'hC);
    stall = 1'b1; #1;
    chk_req("stall_req", 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk_out("stall_hold", 1'b1, 32'hA000_0008, 32'h8, 32'hC);
      chk_req("stall_noreq", 1'b0, 32'h0);
    end
    stall = 1'b0; lat = 2; #1;
    chk_req("req12", 1'b1, 32'hC);
    tick;                                           // request 12, now in WAIT

    // Redirect while in WAIT. The response arrives later and is dropped.
    PCSrcE = 1'b1; PCTargetE = 32'h40; #1;
    chk_req("redir_noreq", 1'b0, 32'h0);
    tick;                                           // WAIT -> DISCARD
    PCSrcE = 1'b0; #1;
    chk_req("discard", 1'b0, 32'h0);
    chk_out("discard", 1'b0, NOP, 32'h0, 32'h0);
    tick;                                           // response dropped
    chk_out("dropped", 1'b0, NOP, 32'h0, 32'h0);
    chk_req("req40", 1'b1, 32'h40);
    lat = 1;
    tick;
    chk_out("wait40", 1'b0, NOP, 32'h0, 32'h0);
    tick;
    chk_out("i40", 1'b1, 32'hA000_0040, 32'h40, 32'h44);
    chk_req("req44", 1'b1, 32'h44);
    tick;                                           // request 0x44; rvalid is high now

    // Redirect in the same cycle as rvalid, with an unaligned target
    PCSrcE = 1'b1; PCTargetE = 32'h43; #1;
    chk_req("redir_rv", 1'b0, 32'h0);
    tick;
    PCSrcE = 1'b0; #1;
    chk_out("rv_dropped", 1'b0, NOP, 32'h0, 32'h0);
    chk_req("req40b", 1'b1, 32'h40);
    tick; tick;
    chk_out("i40b", 1'b1, 32'hA000_0040, 32'h40, 32'h44);

    // Redirect while stalled with a full slot
    stall = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h100; #1;
    chk_req("redir_stall", 1'b0, 32'h0);
    tick;
    PCSrcE = 1'b0; #1;
    chk_out("stall_redir", 1'b0, NOP, 32'h0, 32'h0);
    chk_req("req100", 1'b1, 32'h100);              // slot empty, so stall does not block
    tick; tick;                                     // response fills an empty slot under stall
    chk_out("i100", 1'b1, 32'hA000_0100, 32'h100, 32'h104);
    chk_req("i100_noreq", 1'b0, 32'h0);
    stall = 1'b0; lat = 2; #1;
    chk_req("req104", 1'b1, 32'h104);
    tick;                                           // request 0x104, WAIT

    // Async reset while in WAIT
    #2 rst = 1'b1; #1;
    chk_req("midrst", 1'b0, 32'h0);
    chk_out("midrst", 1'b0, NOP, 32'h0, 32'h0);
    lat = 1;
    tick;
    rst = 1'b0; #1;
    chk_req("post_rst", 1'b1, 32'h0);
    tick; tick;
    chk_out("post_rst_i0", 1'b1, 32'h00A0_0093, 32'h0, 32'h4);

    // Wraparound of fetch_pc and PC_PlusF
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFE; #1;
    tick;
    PCSrcE = 1'b0; #1;
    chk_req("req_top", 1'b1, 32'hFFFF_FFFC);
    tick; tick;
    chk_out("i_top", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0);
    chk_req("req_wrap", 1'b1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- PC/fetch stage directly upstream of the IF/ID pipeline register.
- Generates instruction-memory requests over a one-outstanding req/rvalid interface and holds one returned instruction in an output slot.
- Presents InstrF, PCF and PC_PlusF to IF/ID, which captures them on every cycle it is not stalled.
- Handles execute-stage redirects, including discarding an in-flight response, and emits NOP bubbles when no instruction is ready.

Parameters:
DATA_WIDTH, 32, width of instructions and addresses
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
stall  input  1  hazard-unit stall; the same signal drives the IF/ID register's en (1 = IF/ID holds)
PCSrcE  input  1  redirect request from execute
PCTargetE  input  DATA_WIDTH  redirect target address
imem_req  output  1  request valid; memory samples imem_addr at posedge when high
imem_addr  output  DATA_WIDTH  request address
imem_rvalid  input  1  response valid, at least 1 cycle after the accepted request
imem_rdata  input  DATA_WIDTH  response instruction word
InstrF  output  DATA_WIDTH  instruction to IF/ID (the RDi input)
PCF  output  DATA_WIDTH  PC of InstrF (the pc input)
PC_PlusF  output  DATA_WIDTH  PCF + 4 (the PC_PlusF input)
fetch_valid  output  1  slot holds a real instruction

Behaviour:
- Registers:
  - state ∈ {IDLE, WAIT, DISCARD}
  - fetch_pc: next address to request
  - req_pc: address of the outstanding request
  - slot_valid / slot_instr / slot_pc: output slot
- Async reset:
  - state=IDLE, fetch_pc=RESET_PC, req_pc=0, slot_valid=0, slot_instr=NOP_INSTR, slot_pc=0.
  - imem_req is forced 0 while rst is high.
- Outputs (combinational from the slot):
  - slot_valid=1: InstrF=slot_instr, PCF=slot_pc, PC_PlusF=slot_pc+4, fetch_valid=1.
  - slot_valid=0: InstrF=NOP_INSTR, PCF=0, PC_PlusF=0, fetch_valid=0.
- Consume: at posedge with stall=0 and slot_valid=1, slot_valid<=0, unless refilled in the same edge (never possible in practice, see below).
- imem_req = state==IDLE && !PCSrcE && (!slot_valid || !stall). imem_addr = fetch_pc.
- IDLE with imem_req=1 → WAIT; req_pc<=fetch_pc; fetch_pc<=fetch_pc+4.
- WAIT with imem_rvalid=1 and no redirect → IDLE; slot<={1, imem_rdata, req_pc}.
  - The slot is guaranteed empty at this edge, because requests issue only when the slot is empty or being consumed.
- Redirect (PCSrcE=1) has top priority over stall and over all other transitions:
  - fetch_pc <= {PCTargetE[DW-1:2], 2'b00}; slot_valid <= 0; no request issued that cycle.
  - From WAIT without rvalid → DISCARD.
  - From WAIT with rvalid → IDLE; the response is dropped.
  - From IDLE or DISCARD → state unchanged.
- DISCARD: imem_rvalid=1 → drop the data, → IDLE. Redirects while in DISCARD update only fetch_pc.
- Latency and throughput:
  - Request at edge N, rvalid at N+k (k≥1), instruction visible from N+k until consumed.
  - Next request issues at the following edge at the earliest, so peak throughput is 1 instruction per 2 cycles.
- stall=1 with the slot full: slot and outputs held; no request issued.
- stall=1 with the slot empty: an already-issued response may still fill the slot.
- fetch_pc wraps modulo 2^DATA_WIDTH.
- Reset asserted mid-WAIT: the outstanding request is forgotten. The memory must not deliver rvalid for pre-reset requests after reset; this is the memory's responsibility.

Test Plan:
- Reset, then a memory with 1-cycle latency returning 0x00A00093@0, 0x00100113@4, stall=0 → imem_addr sequence 0,4,8 on req cycles 0,2,4; IF/ID sees (0x00A00093,PCF=0,PC_PlusF=4), bubble NOP, (0x00100113,PCF=4,PC_PlusF=8).
- Slot full with PCF=8, stall held 3 cycles → InstrF/PCF constant, imem_req=0 throughout; after release, next request to addr 12 on the following cycle.
- PCSrcE=1, PCTargetE=0x40 while in WAIT with rvalid 2 cycles later → state DISCARD, response dropped, next imem_addr=0x40, fetch_valid=0 until the 0x40 instruction arrives.
- PCSrcE=1 in the same cycle as rvalid → data dropped, no slot fill; next request to the target; PCTargetE=0x43 yields addr 0x40.
- Redirect while stall=1 and slot full → slot cleared (fetch_valid=0, InstrF=0x00000013) next cycle; fetch resumes at the target.
- Async rst asserted mid-WAIT, no clock edge → imem_req=0 and fetch_valid=0 immediately; after release, first imem_addr=RESET_PC.
